// File: rtl/fpu_result_select.sv
// Final stage of the FPU add/sub path: pairs queued exception-block decisions with
// datapath results in order and presents the IEEE-754 result through a registered valid/ready stage.
`timescale 1ns/1ps
module fpu_result_select #(
    parameter int WIDTH     = 32,
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 23,
    parameter int DEPTH     = 4
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             exc_valid,
    output logic             exc_ready,
    input  logic [2:0]       exception_flag,
    input  logic [WIDTH-2:0] copied_operand,
    input  logic             exc_sign,
    input  logic             dp_valid,
    output logic             dp_ready,
    input  logic [WIDTH-1:0] dp_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             res_special,
    output logic             err_underflow
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = WIDTH + 3;

    localparam logic [WIDTH-1:0] QNAN =
        {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MANT_BITS-1){1'b0}}};

    typedef enum logic [2:0] {
        FLAG_NONE          = 3'b000,
        FLAG_NAN           = 3'b001,
        FLAG_COPY_A        = 3'b010,
        FLAG_COPY_B        = 3'b011,
        FLAG_FIN_MIN_INF   = 3'b100,
        FLAG_ZERO_MIN_ZERO = 3'b101,
        FLAG_ZERO_MIN_SOME = 3'b110,
        FLAG_SUB_SAME_VAL  = 3'b111
    } exc_flag_e;

    logic [ENTRY_W-1:0] fifo_mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               res_valid_q, res_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               res_special_q, res_special_d;
    logic               err_underflow_q, err_underflow_d;

    logic               push, pop;
    logic [ENTRY_W-1:0] head;
    exc_flag_e          head_flag;
    logic               head_sign;
    logic [WIDTH-2:0]   head_mag;
    logic [WIDTH-1:0]   sel_result;

    // Full blocks pushes even when a pop happens the same cycle.
    assign exc_ready = (count_q != CNT_W'(DEPTH));
    assign dp_ready  = (count_q != '0) & (~res_valid_q | res_ready);
    assign push      = exc_valid & exc_ready;
    assign pop       = dp_valid & dp_ready;

    assign head      = fifo_mem_q[rd_ptr_q];
    assign head_flag = exc_flag_e'(head[ENTRY_W-1 -: 3]);
    assign head_sign = head[WIDTH-1];
    assign head_mag  = head[WIDTH-2:0];

    always_comb begin
        sel_result = dp_result;
        case (head_flag)
            FLAG_NONE:          sel_result = dp_result;
            FLAG_NAN:           sel_result = QNAN;
            FLAG_COPY_A,
            FLAG_COPY_B,
            FLAG_ZERO_MIN_SOME: sel_result = {head_sign, head_mag};
            FLAG_FIN_MIN_INF:   sel_result = {head_sign, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
            FLAG_ZERO_MIN_ZERO: sel_result = {head_sign, {(WIDTH-1){1'b0}}};
            FLAG_SUB_SAME_VAL:  sel_result = '0;
        endcase
    end

    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        res_valid_d     = res_valid_q;
        result_d        = result_q;
        res_special_d   = res_special_q;
        err_underflow_d = err_underflow_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);

        if (pop) begin
            res_valid_d   = 1'b1;
            result_d      = sel_result;
            res_special_d = (head_flag != FLAG_NONE);
        end else if (res_ready) begin
            res_valid_d   = 1'b0;
        end

        if (dp_valid && (count_q == '0)) err_underflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {exception_flag, exc_sign, copied_operand};
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            res_valid_q     <= 1'b0;
            result_q        <= '0;
            res_special_q   <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            res_valid_q     <= res_valid_d;
            result_q        <= result_d;
            res_special_q   <= res_special_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign res_valid     = res_valid_q;
    assign result        = result_q;
    assign res_special   = res_special_q;
    assign err_underflow = err_underflow_q;

endmodule
